sa_operand_skewer: RTL



---
 rtl/sa_pkg.sv | 18 +
 rtl/sa_skew_lane.sv | 27 ++
 rtl/sa_operand_skewer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared constants, FSM states and stream length helper for the operand skewer
package sa_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int ACC_WIDTH      = 32;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2
    } skew_state_t;

    // Number of cycles needed to push the full skewed wavefront through the widest edge.
    function automatic int stream_len(input int k, input int m, input int n);
        return k + ((m > n) ? m : n) - 1;
    endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// rtl/sa_skew_lane.sv - one edge lane: picks operand k = t - LANE when it lies inside the tile
module sa_skew_lane #(
    parameter int K          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TW         = 3,
    parameter int LANE       = 0
) (
    input  logic [TW-1:0]           t,
    input  logic [K*DATA_WIDTH-1:0] slice,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    vld
);

    int k;

    // Lane i lags the wavefront by i cycles; outside the tile the lane is forced to zero.
    always_comb begin
        k    = int'(t) - LANE;
        data = '0;
        vld  = 1'b0;
        if (k >= 0 && k < K) begin
            data = slice[k*DATA_WIDTH +: DATA_WIDTH];
            vld  = 1'b1;
        end
    end

endmodule

// File: rtl/sa_operand_skewer.sv
// rtl/sa_operand_skewer.sv - buffers one A/B tile and replays it as skewed west/north wavefronts (SA_SKEW_DBUF_EN: ping/pong buffers)
module sa_operand_skewer
    import sa_pkg::*;
#(
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [M*DATA_WIDTH-1:0] in_a_col,
    input  logic [N*DATA_WIDTH-1:0] in_b_row,
    input  logic                    in_last,
    input  logic                    array_idle,
    output logic [M*DATA_WIDTH-1:0] a_out,
    output logic [M-1:0]            a_vld,
    output logic [N*DATA_WIDTH-1:0] b_out,
    output logic [N-1:0]            b_vld,
    output logic                    tile_start,
    output logic                    tile_done,
    output logic                    err_len
);

    localparam int L  = stream_len(K, M, N);
    localparam int TW = (L > 1) ? $clog2(L) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int SW = K * DATA_WIDTH;

    skew_state_t             state;
    logic [KW-1:0]           kcnt;
    logic [TW-1:0]           tcnt;
    logic                    wr_sel;
    logic                    rd_sel;
    logic [SW-1:0]           a_buf [2][M];
    logic [SW-1:0]           b_buf [2][N];
    logic                    accept;
    logic                    load_done;
    logic                    t_last;
    logic [M*DATA_WIDTH-1:0] a_nxt;
    logic [M-1:0]            a_nv;
    logic [N*DATA_WIDTH-1:0] b_nxt;
    logic [N-1:0]            b_nv;

    assign accept    = in_valid && in_ready;
    assign load_done = accept && (kcnt == KW'(K-1));
    assign t_last    = (tcnt == TW'(L-1));

    // Beat counter and sticky length check: in_last must coincide exactly with the final beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kcnt    <= '0;
            err_len <= 1'b0;
        end else if (accept) begin
            if (in_last != (kcnt == KW'(K-1)))
                err_len <= 1'b1;
            kcnt <= load_done ? '0 : kcnt + 1'b1;
        end
    end

    // Tile storage: lane i of A keeps its K values of row i, lane j of B keeps column j.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < M; i++) a_buf[s][i] <= '0;
                for (int j = 0; j < N; j++) b_buf[s][j] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < M; i++)
                a_buf[wr_sel][i][int'(kcnt)*DATA_WIDTH +: DATA_WIDTH] <= in_a_col[i*DATA_WIDTH +: DATA_WIDTH];
            for (int j = 0; j < N; j++)
                b_buf[wr_sel][j][int'(kcnt)*DATA_WIDTH +: DATA_WIDTH] <= in_b_row[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef SA_SKEW_DBUF_EN
    logic [1:0] full;

    assign in_ready = !full[wr_sel];

    // Loader fills the free buffer while the stream side drains the other; a waiting full buffer chains without a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_LOAD;
            tcnt   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            full   <= '0;
        end else begin
            case (state)
                ST_LOAD, ST_WAIT: begin
                    if (full[rd_sel]) begin
                        if (array_idle) begin
                            state <= ST_STREAM;
                            tcnt  <= '0;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_STREAM: begin
                    if (t_last) begin
                        full[rd_sel] <= 1'b0;
                        rd_sel       <= ~rd_sel;
                        tcnt         <= '0;
                        if (full[~rd_sel] && array_idle) state <= ST_STREAM;
                        else if (full[~rd_sel])          state <= ST_WAIT;
                        else                             state <= ST_LOAD;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
            if (load_done) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
            end
        end
    end
`else
    assign in_ready = (state == ST_LOAD);
    assign wr_sel   = 1'b0;
    assign rd_sel   = 1'b0;

    // Single buffer: load K beats, wait for the array, then stream L cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_LOAD;
            tcnt  <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_done) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (array_idle) begin
                        state <= ST_STREAM;
                        tcnt  <= '0;
                    end
                end
                ST_STREAM: begin
                    if (t_last) begin
                        state <= ST_LOAD;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end
`endif

    for (genvar i = 0; i < M; i++) begin : g_a_lane
        sa_skew_lane #(.K(K), .DATA_WIDTH(DATA_WIDTH), .TW(TW), .LANE(i)) u_lane (
            .t     (tcnt),
            .slice (a_buf[rd_sel][i]),
            .data  (a_nxt[i*DATA_WIDTH +: DATA_WIDTH]),
            .vld   (a_nv[i])
        );
    end

    for (genvar j = 0; j < N; j++) begin : g_b_lane
        sa_skew_lane #(.K(K), .DATA_WIDTH(DATA_WIDTH), .TW(TW), .LANE(j)) u_lane (
            .t     (tcnt),
            .slice (b_buf[rd_sel][j]),
            .data  (b_nxt[j*DATA_WIDTH +: DATA_WIDTH]),
            .vld   (b_nv[j])
        );
    end

    // Edge outputs are registered one cycle behind the stream counter and held at zero outside STREAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_out      <= '0;
            a_vld      <= '0;
            b_out      <= '0;
            b_vld      <= '0;
            tile_start <= 1'b0;
            tile_done  <= 1'b0;
        end else if (state == ST_STREAM) begin
            a_out      <= a_nxt;
            a_vld      <= a_nv;
            b_out      <= b_nxt;
            b_vld      <= b_nv;
            tile_start <= (tcnt == '0);
            tile_done  <= t_last;
        end else begin
            a_out      <= '0;
            a_vld      <= '0;
            b_out      <= '0;
            b_vld      <= '0;
            tile_start <= 1'b0;
            tile_done  <= 1'b0;
        end
    end

endmodule
